// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main-memory port between I-cache and D-cache burst transfers.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the D-cache wins ties.
module mem_arbiter #(
    parameter int LAT   = 2,
    parameter int BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ic_req,
    input  logic [15:0]                ic_addr,
    output logic                       ic_gnt,
    output logic                       ic_rvalid,
    output logic [15:0]                ic_rdata,
    output logic [$clog2(BURST)-1:0]   ic_beat,
    output logic                       ic_done,
    input  logic                       dc_req,
    input  logic                       dc_wr,
    input  logic [15:0]                dc_addr,
    input  logic [15:0]                dc_wdata,
    output logic [$clog2(BURST)-1:0]   dc_wbeat,
    output logic                       dc_gnt,
    output logic                       dc_rvalid,
    output logic [15:0]                dc_rdata,
    output logic [$clog2(BURST)-1:0]   dc_beat,
    output logic                       dc_done,
    output logic                       mem_rd,
    output logic                       mem_wr,
    output logic [15:0]                mem_addr,
    output logic [15:0]                mem_wdata,
    input  logic                       mem_stall,
    input  logic [15:0]                mem_rdata
);
    localparam int BW = $clog2(BURST);
    localparam logic [LAT-1:0] TOP = LAT'(1) << (LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                 state, state_nx;
    logic                   owner_dc, wr_q, pick_dc, any_req;
    logic [15:0]            base;
    logic [BW-1:0]          beat;
    logic [LAT-1:0]         pv;
    logic [LAT-1:0][BW-1:0] pb;
    logic                   accept, last_beat, drain_done, busy, rv_out;
    logic [BW-1:0]          tag;

    assign any_req    = ic_req | dc_req;
    assign accept     = (state == ISSUE) && !mem_stall;
    assign last_beat  = beat == BW'(BURST - 1);
    // Done once every in-flight read except the one returning now has left the pipe.
    assign drain_done = (state == DRAIN) && ((pv & ~TOP) == '0);
    assign busy       = state != IDLE;
    assign rv_out     = pv[LAT-1];
    assign tag        = pb[LAT-1];

`ifdef MEM_ARB_RR_EN
    logic last_dc;

    assign pick_dc = dc_req && (!ic_req || !last_dc);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_dc <= 1'b0;
        end else if (state == IDLE && ic_req && dc_req) begin
            last_dc <= pick_dc;
        end
    end
`else
    assign pick_dc = dc_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner_dc <= 1'b0;
            wr_q     <= 1'b0;
            base     <= '0;
            beat     <= '0;
            pv       <= '0;
            pb       <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                owner_dc <= pick_dc;
                wr_q     <= pick_dc & dc_wr;
                base     <= pick_dc ? dc_addr : ic_addr;
                beat     <= '0;
            end else if (accept) begin
                beat <= beat + 1'b1;
            end
            for (int i = LAT - 1; i > 0; i--) begin
                pv[i] <= pv[i-1];
                pb[i] <= pb[i-1];
            end
            pv[0] <= accept & ~wr_q;
            pb[0] <= beat;
        end
    end

    always_comb begin
        state_nx  = state;
        ic_gnt    = 1'b0;
        ic_rvalid = 1'b0;
        ic_rdata  = '0;
        ic_beat   = '0;
        ic_done   = 1'b0;
        dc_gnt    = 1'b0;
        dc_rvalid = 1'b0;
        dc_rdata  = '0;
        dc_beat   = '0;
        dc_done   = 1'b0;
        dc_wbeat  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        unique case (state)
            IDLE:    if (any_req) state_nx = ISSUE;
            ISSUE:   if (accept && last_beat) state_nx = DRAIN;
            DRAIN:   if (drain_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (state == ISSUE) begin
            mem_rd   = !wr_q;
            mem_wr   = wr_q;
            mem_addr = base + 16'({beat, 1'b0});
            if (wr_q) mem_wdata = dc_wdata;
            if (owner_dc) dc_wbeat = beat;
        end

        if (busy && owner_dc) begin
            dc_gnt    = 1'b1;
            dc_rvalid = rv_out;
            dc_rdata  = rv_out ? mem_rdata : '0;
            dc_beat   = rv_out ? tag : '0;
            dc_done   = drain_done;
        end else if (busy) begin
            ic_gnt    = 1'b1;
            ic_rvalid = rv_out;
            ic_rdata  = rv_out ? mem_rdata : '0;
            ic_beat   = rv_out ? tag : '0;
            ic_done   = drain_done;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with a transaction-level model checked every cycle.
module tb_mem_arbiter;
    localparam int LAT   = 2;
    localparam int BURST = 4;
    localparam int BW    = 2;
`ifdef MEM_ARB_RR_EN
    localparam bit TIE2_DC = 1'b0;
`else
    localparam bit TIE2_DC = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ic_req = 1'b0;
    logic [15:0]   ic_addr = '0;
    logic          ic_gnt, ic_rvalid, ic_done;
    logic [15:0]   ic_rdata;
    logic [BW-1:0] ic_beat;
    logic          dc_req = 1'b0;
    logic          dc_wr = 1'b0;
    logic [15:0]   dc_addr = '0;
    logic [15:0]   dc_wdata;
    logic [BW-1:0] dc_wbeat;
    logic          dc_gnt, dc_rvalid, dc_done;
    logic [15:0]   dc_rdata;
    logic [BW-1:0] dc_beat;
    logic          mem_rd, mem_wr;
    logic [15:0]   mem_addr, mem_wdata;
    logic          mem_stall = 1'b0;
    logic [15:0]   mem_rdata = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit checking = 1'b0;
    logic [15:0] rd_at [int];

    mem_arbiter #(.LAT(LAT), .BURST(BURST)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
        .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .ic_beat(ic_beat),
        .ic_done(ic_done),
        .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_wbeat(dc_wbeat), .dc_gnt(dc_gnt),
        .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_beat(dc_beat),
        .dc_done(dc_done),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_stall(mem_stall), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // D-cache write data: word k of a line is 0x1111*(k+1)
    assign dc_wdata = 16'(16'h1111 * (int'(dc_wbeat) + 1));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_done(input bit dc, input string n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            settle();
            seen = dc ? dc_done : ic_done;
        end
        chk(n, 32'(seen), 32'd1);
    endtask

    // Memory: returns addr^0xA5A5 LAT cycles after an accepted read.
    initial begin : memory
        forever begin
            @(posedge clk);
            #1;
            mem_rdata = rd_at.exists(cyc - LAT) ?
                        (rd_at[cyc - LAT] ^ 16'hA5A5) : 16'h0BAD;
        end
    end

    // Transaction model: one owner at a time, BURST accepted issues,
    // reads come back LAT cycles after acceptance, done with the last one.
    initial begin : model
        bit          busy, m_dc, m_wr, iss, rv, dn, pick;
        bit          last_tie_dc;
        logic [15:0] m_base, exp_rd, exp_ad;
        int          issued, rb, left;
        int          pdue[$];
        int          pbeat[$];
        busy = 0; m_dc = 0; m_wr = 0; m_base = 0; issued = 0;
        last_tie_dc = 0;
        forever begin
            @(negedge clk);
            iss    = busy && issued < BURST;
            rv     = pdue.size() > 0 && pdue[0] == cyc;
            rb     = rv ? pbeat[0] : 0;
            left   = pdue.size() - (rv ? 1 : 0);
            dn     = busy && !iss && left == 0;
            exp_rd = rv ? (16'(m_base + 16'(2 * rb)) ^ 16'hA5A5) : 16'h0;
            exp_ad = iss ? 16'(m_base + 16'(2 * issued)) : 16'h0;
            if (checking) begin
                chk("ic_gnt", 32'(ic_gnt), 32'(busy && !m_dc));
                chk("ic_rvalid", 32'(ic_rvalid), 32'(rv && !m_dc));
                chk("ic_rdata", 32'(ic_rdata), m_dc ? 32'd0 : 32'(exp_rd));
                chk("ic_beat", 32'(ic_beat), (rv && !m_dc) ? rb : 0);
                chk("ic_done", 32'(ic_done), 32'(dn && !m_dc));
                chk("dc_gnt", 32'(dc_gnt), 32'(busy && m_dc));
                chk("dc_rvalid", 32'(dc_rvalid), 32'(rv && m_dc));
                chk("dc_rdata", 32'(dc_rdata), m_dc ? 32'(exp_rd) : 32'd0);
                chk("dc_beat", 32'(dc_beat), (rv && m_dc) ? rb : 0);
                chk("dc_done", 32'(dc_done), 32'(dn && m_dc));
                chk("dc_wbeat", 32'(dc_wbeat), (iss && m_dc) ? issued : 0);
                chk("mem_rd", 32'(mem_rd), 32'(iss && !m_wr));
                chk("mem_wr", 32'(mem_wr), 32'(iss && m_wr));
                chk("mem_addr", 32'(mem_addr), 32'(exp_ad));
                chk("mem_wdata", 32'(mem_wdata),
                    (iss && m_wr) ? 32'(16'(16'h1111 * (issued + 1))) : 32'd0);
            end
            if (mem_rd && !mem_stall) rd_at[cyc] = mem_addr;
            if (rst) begin
                busy = 0;
                issued = 0;
                pdue.delete();
                pbeat.delete();
                last_tie_dc = 0;
            end else if (!busy) begin
                if (ic_req || dc_req) begin
`ifdef MEM_ARB_RR_EN
                    if (ic_req && dc_req) begin
                        pick = !last_tie_dc;
                        last_tie_dc = pick;
                    end else begin
                        pick = dc_req;
                    end
`else
                    pick = dc_req;
`endif
                    busy   = 1;
                    m_dc   = pick;
                    m_wr   = pick && dc_wr;
                    m_base = pick ? dc_addr : ic_addr;
                    issued = 0;
                end
            end else begin
                if (rv) begin
                    void'(pdue.pop_front());
                    void'(pbeat.pop_front());
                end
                if (iss && !mem_stall) begin
                    if (!m_wr) begin
                        pdue.push_back(cyc + LAT);
                        pbeat.push_back(issued);
                    end
                    issued++;
                end
                if (dn) busy = 0;
            end
            cyc++;
        end
    end

    initial begin : stim
        bit w;
        tick();
        tick();
        checking = 1'b1;
        settle();
        chk("rst_gnt", {ic_gnt, dc_gnt}, 0);
        chk("rst_mem", {mem_rd, mem_wr, mem_addr}, 0);
        chk("rst_rd", {ic_rdata, dc_rdata}, 0);
        rst = 1'b0;

        // line fill, I-cache
        tick(); ic_req = 1; ic_addr = 16'h0040; settle();
        chk("t1_c0_gnt", ic_gnt, 0);
        tick(); ic_req = 0; settle();
        chk("t1_c1_addr", mem_addr, 16'h0040);
        chk("t1_c1_gnt", {ic_gnt, mem_rd}, 2'b11);
        tick(); tick(); settle();
        chk("t1_c3_beat0", {ic_rvalid, ic_beat, ic_rdata}, {1'b1, 2'd0, 16'hA5E5});
        tick(); tick(); tick(); settle();
        chk("t1_c6_done", {ic_done, ic_beat, ic_rdata}, {1'b1, 2'd3, 16'hA5E3});
        tick(); settle();
        chk("t1_c7_idle", ic_gnt, 0);

        // writeback, D-cache; mid-transaction input changes ignored
        tick(); dc_req = 1; dc_wr = 1; dc_addr = 16'h1000;
        tick(); dc_req = 0; dc_wr = 0; settle();
        chk("t2_c1_wr", {mem_wr, mem_rd}, 2'b10);
        chk("t2_c1_data", {mem_addr, mem_wdata}, {16'h1000, 16'h1111});
        tick(); tick(); tick(); settle();
        chk("t2_c4_data", {mem_addr, mem_wdata}, {16'h1006, 16'h4444});
        tick(); settle();
        chk("t2_c5_done", {dc_done, dc_rvalid, mem_wr}, 3'b100);
        tick();

        // simultaneous requests
        tick(); ic_req = 1; ic_addr = 16'h0080;
        dc_req = 1; dc_wr = 0; dc_addr = 16'h2000;
        tick(); settle();
        chk("t3_first_dc", {dc_gnt, ic_gnt}, 2'b10);
        wait_done(1, "t3_dc_done");
        tick(); dc_req = 0;
        tick(); settle();
        chk("t3_then_ic", {dc_gnt, ic_gnt}, 2'b01);
        wait_done(0, "t3_ic_done");
        tick(); ic_req = 0;
        tick(); ic_req = 1; dc_req = 1;
        w = TIE2_DC;
        tick(); settle();
        chk("t3_rereq", {dc_gnt, ic_gnt}, w ? 2'b10 : 2'b01);
        wait_done(w, "t3_w_done");
        tick();
        if (w) dc_req = 0; else ic_req = 0;
        tick(); settle();
        chk("t3_other", {dc_gnt, ic_gnt}, w ? 2'b01 : 2'b10);
        wait_done(!w, "t3_o_done");
        tick(); ic_req = 0; dc_req = 0;
        tick();

        // stall on beat 1 for 3 cycles
        tick(); ic_req = 1; ic_addr = 16'h0040;
        tick(); ic_req = 0;
        tick(); mem_stall = 1;
        tick();
        tick(); settle();
        chk("t4_c4_addr", mem_addr, 16'h0042);
        tick(); mem_stall = 0; settle();
        chk("t4_c5_addr", {mem_rd, mem_addr}, {1'b1, 16'h0042});
        tick(); tick(); tick(); tick(); settle();
        chk("t4_c9_done", {ic_done, ic_beat}, {1'b1, 2'd3});
        tick(); settle();
        chk("t4_c10_idle", ic_gnt, 0);

        // reset during DRAIN
        tick(); ic_req = 1; ic_addr = 16'h0100;
        tick(); ic_req = 0;
        tick(); tick(); tick(); tick();
        rst = 1; settle();
        chk("t5_c5_rv", {ic_gnt, ic_rvalid, ic_beat}, {1'b1, 1'b1, 2'd2});
        tick(); rst = 0; settle();
        chk("t5_c6_zero", {ic_gnt, ic_rvalid, ic_done, mem_rd, mem_addr}, 0);
        tick(); ic_req = 1; ic_addr = 16'h0200; settle();
        chk("t5_c7_quiet", {ic_rvalid, ic_done, ic_gnt}, 0);
        tick(); ic_req = 0; settle();
        chk("t5_regrant", {ic_gnt, mem_addr}, {1'b1, 16'h0200});
        wait_done(0, "t5_done");
        tick();

        // top-of-memory line
        tick(); ic_req = 1; ic_addr = 16'hFFF8;
        tick(); ic_req = 0; settle();
        chk("t6_c1", mem_addr, 16'hFFF8);
        tick(); tick(); tick(); settle();
        chk("t6_c4", mem_addr, 16'hFFFE);
        tick(); tick(); settle();
        chk("t6_c6", {ic_done, ic_rdata}, {1'b1, 16'h5A5B});
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
